// File: rtl/bird_gen.sv
// bird_gen: small multi-cycle accumulator-free CPU with 8 registers (r7 = stack pointer).
// Define BIRD_IRQ_EN to add the level interrupt (IRQ state, ie flag, irq_ack pulse).
module bird_gen #(
  parameter int          DATA_W  = 16,
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] SP_INIT = 32'h1FF,
  parameter logic [31:0] IRQ_VEC = 32'h010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] address,
  output logic              memwt,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic              halted,
  input  logic              irq,
  output logic              irq_ack
);

  localparam logic [3:0] S_FETCH = 4'h0;
  localparam logic [3:0] S_LDI   = 4'h1;
  localparam logic [3:0] S_LD    = 4'h2;
  localparam logic [3:0] S_ST    = 4'h3;
  localparam logic [3:0] S_JMP   = 4'h5;
  localparam logic [3:0] S_HALT  = 4'h6;
  localparam logic [3:0] S_ALU   = 4'h7;
  localparam logic [3:0] S_PUSH  = 4'h8;
  localparam logic [3:0] S_POP1  = 4'h9;
  localparam logic [3:0] S_CALL  = 4'hA;
  localparam logic [3:0] S_RET1  = 4'hB;
  localparam logic [3:0] S_POP2  = 4'hC;
  localparam logic [3:0] S_RET2  = 4'hD;
`ifdef BIRD_IRQ_EN
  localparam logic [3:0] S_IRQ   = 4'hE;
`endif

  localparam logic [DATA_W-1:0] D_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [3:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [11:0]       ir;
  logic              zeroflag;
  logic [DATA_W-1:0] regs [8];

  logic [3:0]        opcode;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] pc_ext;
  logic [DATA_W-1:0] alu_res;

  assign opcode = data_in[DATA_W-1 -: 4];
  assign src_a  = regs[ir[8:6]];
  assign src_b  = regs[ir[5:3]];
  assign sp     = regs[7];
  assign pc_ext = {{(DATA_W-ADDR_W){1'b0}}, pc};
  assign halted = (state == S_HALT);

`ifdef BIRD_IRQ_EN
  logic ie;
  logic irq_ack_r;
  logic irq_take;
  assign irq_take = irq & ie & (((state == S_FETCH) & mem_ready) | (state == S_HALT));
  assign irq_ack  = irq_ack_r;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_ack    = 1'b0;
`endif

  // ALU result for the instruction held in ir
  always_comb begin
    alu_res = '0;
    case (ir[11:9])
      3'd0: alu_res = src_a + src_b;
      3'd1: alu_res = src_a - src_b;
      3'd2: alu_res = src_a & src_b;
      3'd3: alu_res = src_a | src_b;
      3'd4: alu_res = src_a ^ src_b;
      3'd7: begin
        case (ir[8:6])
          3'd0:    alu_res = ~src_b;
          3'd1:    alu_res = src_b;
          3'd2:    alu_res = src_b + D_ONE;
          3'd3:    alu_res = src_b - D_ONE;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Memory bus decode; depends only on state registers so it is stable while stalled
  always_comb begin
    address  = pc;
    data_out = '0;
    memwt    = 1'b0;
    mem_req  = 1'b0;
    case (state)
      S_FETCH, S_LDI: mem_req = 1'b1;
      S_LD: begin
        mem_req = 1'b1;
        address = src_b[ADDR_W-1:0];
      end
      S_ST: begin
        mem_req  = 1'b1;
        memwt    = 1'b1;
        address  = src_b[ADDR_W-1:0];
        data_out = src_a;
      end
      S_PUSH: begin
        mem_req  = 1'b1;
        memwt    = 1'b1;
        address  = sp[ADDR_W-1:0];
        data_out = src_b;
      end
      S_CALL: begin
        mem_req  = 1'b1;
        memwt    = 1'b1;
        address  = sp[ADDR_W-1:0];
        data_out = pc_ext;
      end
`ifdef BIRD_IRQ_EN
      S_IRQ: begin
        mem_req  = 1'b1;
        memwt    = 1'b1;
        address  = sp[ADDR_W-1:0];
        data_out = pc_ext;
      end
`endif
      S_POP2, S_RET2: begin
        mem_req = 1'b1;
        address = sp[ADDR_W-1:0];
      end
      default: mem_req = 1'b0;
    endcase
  end

  // Sequencer, register file, PC and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      zeroflag <= 1'b0;
      for (int i = 0; i < 7; i++) regs[i] <= '0;
      regs[7]  <= SP_INIT[DATA_W-1:0];
`ifdef BIRD_IRQ_EN
      ie        <= 1'b1;
      irq_ack_r <= 1'b0;
`endif
    end else begin
`ifdef BIRD_IRQ_EN
      irq_ack_r <= 1'b0;
`endif
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
`ifdef BIRD_IRQ_EN
            if (irq_take) begin
              state     <= S_IRQ;
              irq_ack_r <= 1'b1;
            end else
`endif
            begin
              ir <= data_in[11:0];
              pc <= pc + PC_ONE;
              case (opcode)
                4'h1:    state <= S_LDI;
                4'h2:    state <= S_LD;
                4'h3:    state <= S_ST;
                4'h4:    state <= zeroflag ? S_JMP : S_FETCH;
                4'h5:    state <= S_JMP;
                4'h6:    state <= S_HALT;
                4'h7:    state <= S_ALU;
                4'h8:    state <= S_PUSH;
                4'h9:    state <= S_POP1;
                4'hA:    state <= S_CALL;
                4'hB:    state <= S_RET1;
                default: state <= S_FETCH;
              endcase
            end
          end
        end
        S_LDI: if (mem_ready) begin
          regs[ir[2:0]] <= data_in;
          pc            <= pc + PC_ONE;
          state         <= S_FETCH;
        end
        S_LD: if (mem_ready) begin
          regs[ir[2:0]] <= data_in;
          state         <= S_FETCH;
        end
        S_ST: if (mem_ready) state <= S_FETCH;
        S_JMP: begin
          pc    <= pc + ir[ADDR_W-1:0];
          state <= S_FETCH;
        end
        S_HALT: begin
`ifdef BIRD_IRQ_EN
          if (irq_take) begin
            state     <= S_IRQ;
            irq_ack_r <= 1'b1;
          end
`endif
        end
        S_ALU: begin
          regs[ir[2:0]] <= alu_res;
          zeroflag      <= (alu_res == '0);
          state         <= S_FETCH;
        end
        S_PUSH: if (mem_ready) begin
          regs[7] <= sp - D_ONE;
          state   <= S_FETCH;
        end
        S_POP1: begin
          regs[7] <= sp + D_ONE;
          state   <= S_POP2;
        end
        S_POP2: if (mem_ready) begin
          regs[ir[2:0]] <= data_in;
          state         <= S_FETCH;
        end
        S_CALL: if (mem_ready) begin
          regs[7] <= sp - D_ONE;
          pc      <= pc + ir[ADDR_W-1:0];
          state   <= S_FETCH;
        end
        S_RET1: begin
          regs[7] <= sp + D_ONE;
          state   <= S_RET2;
        end
        S_RET2: if (mem_ready) begin
          pc    <= data_in[ADDR_W-1:0];
          state <= S_FETCH;
`ifdef BIRD_IRQ_EN
          ie    <= 1'b1;
`endif
        end
`ifdef BIRD_IRQ_EN
        S_IRQ: if (mem_ready) begin
          regs[7] <= sp - D_ONE;
          pc      <= IRQ_VEC[ADDR_W-1:0];
          ie      <= 1'b0;
          state   <= S_FETCH;
        end
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_bird_gen.sv
// Directed bench for bird_gen: one 16/12 instance driven by small programs, one 32/8 instance.
module tb_bird_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, b_rst_n, mem_ready, irq, b_irq;
  int total = 0;
  int bad = 0;

  logic [15:0] a_data_in, a_data_out;
  logic [11:0] a_address;
  logic        a_memwt, a_mem_req, a_halted, a_irq_ack;

  logic [31:0] b_data_in, b_data_out;
  logic [7:0]  b_address;
  logic        b_memwt, b_mem_req, b_halted, b_irq_ack;

  bird_gen #(.DATA_W(16), .ADDR_W(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_data_in), .data_out(a_data_out),
    .address(a_address), .memwt(a_memwt), .mem_req(a_mem_req), .mem_ready(mem_ready),
    .halted(a_halted), .irq(irq), .irq_ack(a_irq_ack));

  bird_gen #(.DATA_W(32), .ADDR_W(8)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .data_in(b_data_in), .data_out(b_data_out),
    .address(b_address), .memwt(b_memwt), .mem_req(b_mem_req), .mem_ready(mem_ready),
    .halted(b_halted), .irq(b_irq), .irq_ack(b_irq_ack));

  // Memory models with load port and write log
  logic [15:0] mem_a [4096];
  logic [31:0] mem_b [256];
  logic        fill_a = 1'b0, fill_b = 1'b0, ld_a_en = 1'b0, ld_b_en = 1'b0;
  logic [11:0] ld_a_addr = '0;
  logic [15:0] ld_a_data = '0;
  logic [7:0]  ld_b_addr = '0;
  logic [31:0] ld_b_data = '0;
  logic [11:0] wa_addr [64];
  logic [15:0] wa_data [64];
  int wa_cnt = 0;
  int ack_cnt = 0;
  int wb_cnt = 0;

  assign a_data_in = mem_a[a_address];
  assign b_data_in = mem_b[b_address];

  always @(posedge clk) begin
    if (fill_a) begin
      for (int i = 0; i < 4096; i++) mem_a[i] <= 16'h6000;
    end else if (ld_a_en) begin
      mem_a[ld_a_addr] <= ld_a_data;
    end else if (a_memwt && mem_ready) begin
      mem_a[a_address] <= a_data_out;
      if (wa_cnt < 64) begin
        wa_addr[wa_cnt] <= a_address;
        wa_data[wa_cnt] <= a_data_out;
      end
      wa_cnt <= wa_cnt + 1;
    end
    if (a_irq_ack) ack_cnt <= ack_cnt + 1;
  end

  always @(posedge clk) begin
    if (fill_b) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 32'h6000_0000;
    end else if (ld_b_en) begin
      mem_b[ld_b_addr] <= ld_b_data;
    end else if (b_memwt && mem_ready) begin
      mem_b[b_address] <= b_data_out;
      wb_cnt <= wb_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [11:0] addr, input logic [15:0] d);
    ld_a_en = 1'b1; ld_a_addr = addr; ld_a_data = d;
    step();
    ld_a_en = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] addr, input logic [31:0] d);
    ld_b_en = 1'b1; ld_b_addr = addr; ld_b_data = d;
    step();
    ld_b_en = 1'b0;
  endtask

  task automatic clear_a();
    fill_a = 1'b1;
    step();
    fill_a = 1'b0;
  endtask

  task automatic run_a(input int budget, input string tag);
    int n = 0;
    while (!a_halted && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(a_halted), 32'h1);
  endtask

  task automatic load_prog2();
    clear_a();
    load_a(12'h000, 16'h1001); load_a(12'h001, 16'h1234);
    load_a(12'h002, 16'h1002); load_a(12'h003, 16'h0200);
    load_a(12'h004, 16'h3050); load_a(12'h005, 16'hA020);
    load_a(12'h006, 16'h8008); load_a(12'h007, 16'h9004);
    load_a(12'h008, 16'h7E92); load_a(12'h009, 16'h3110);
    load_a(12'h00A, 16'h7E92); load_a(12'h00B, 16'h31D0);
    load_a(12'h00C, 16'h6000); load_a(12'h026, 16'hB000);
  endtask

  initial begin
    int n;
    int base;
    int abase;
    rst_n = 1'b0; b_rst_n = 1'b0; mem_ready = 1'b1; irq = 1'b0; b_irq = 1'b0;

    // Program 1: LDI/ALU sub/JZ taken, ALU add/JZ not taken, INC, ST, HALT
    clear_a();
    load_a(12'h000, 16'h1001); load_a(12'h001, 16'h0005);
    load_a(12'h002, 16'h1002); load_a(12'h003, 16'h0005);
    load_a(12'h004, 16'h7253); load_a(12'h005, 16'h4002);
    load_a(12'h006, 16'h1003); load_a(12'h007, 16'h00FF);
    load_a(12'h008, 16'h1004); load_a(12'h009, 16'h0100);
    load_a(12'h00A, 16'h30E0); load_a(12'h00B, 16'h7055);
    load_a(12'h00C, 16'h4003); load_a(12'h00D, 16'h7EA4);
    load_a(12'h00E, 16'h3160); load_a(12'h00F, 16'h6000);

    check("rst_address", 32'(a_address), 32'h0);
    check("rst_memwt", 32'(a_memwt), 32'h0);
    check("rst_mem_req", 32'(a_mem_req), 32'h1);
    check("rst_halted", 32'(a_halted), 32'h0);
    check("rst_irq_ack", 32'(a_irq_ack), 32'h0);

    rst_n = 1'b1;
    run_a(200, "p1_halt");
    check("p1_r3_zero", 32'(mem_a[12'h100]), 32'h0);
    check("p1_r5_sum", 32'(mem_a[12'h101]), 32'h000A);
    check("p1_untouched", 32'(mem_a[12'h102]), 32'h6000);
    check("p1_pc", 32'(a_address), 32'h010);
    check("p1_halt_noreq", 32'(a_mem_req), 32'h0);

    // Program 2: stalled ST, CALL/RET, PUSH/POP
    rst_n = 1'b0;
    load_prog2();
    base = wa_cnt;
    rst_n = 1'b1;
    n = 0;
    while (!a_memwt && n < 50) begin step(); n++; end
    check("p2_st_reached", 32'(a_memwt), 32'h1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_address", 32'(a_address), 32'h200);
      check("stall_data", 32'(a_data_out), 32'h1234);
      check("stall_memwt", 32'(a_memwt), 32'h1);
    end
    check("stall_no_write", 32'(wa_cnt - base), 32'h0);
    mem_ready = 1'b1;
    step();
    check("stall_one_write", 32'(wa_cnt - base), 32'h1);
    run_a(200, "p2_halt");
    check("p2_writes", 32'(wa_cnt - base), 32'h5);
    check("p2_w0_addr", 32'(wa_addr[base]), 32'h200);
    check("p2_call_addr", 32'(wa_addr[base+1]), 32'h1FF);
    check("p2_call_ret", 32'(wa_data[base+1]), 32'h0006);
    check("p2_push_addr", 32'(wa_addr[base+2]), 32'h1FF);
    check("p2_push_data", 32'(wa_data[base+2]), 32'h1234);
    check("p2_pop_r4", 32'(mem_a[12'h201]), 32'h1234);
    check("p2_sp_restored", 32'(mem_a[12'h202]), 32'h01FF);
    check("p2_pc", 32'(a_address), 32'h00D);

    // Reset during a stalled ST aborts the write at once
    rst_n = 1'b0;
    load_prog2();
    base = wa_cnt;
    rst_n = 1'b1;
    n = 0;
    while (!a_memwt && n < 50) begin step(); n++; end
    check("p3_st_reached", 32'(a_memwt), 32'h1);
    mem_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_memwt", 32'(a_memwt), 32'h0);
    check("async_address", 32'(a_address), 32'h0);
    mem_ready = 1'b1;
    step();
    check("async_no_write", 32'(wa_cnt - base), 32'h0);

    // Interrupt while halted
    clear_a();
    base = wa_cnt;
    abase = ack_cnt;
    rst_n = 1'b1;
    run_a(20, "irq_first_halt");
    check("irq_halt_pc", 32'(a_address), 32'h001);
    irq = 1'b1;
`ifdef BIRD_IRQ_EN
    n = 0;
    while (!a_irq_ack && n < 10) begin step(); n++; end
    check("irq_ack_seen", 32'(a_irq_ack), 32'h1);
    check("irq_not_halted", 32'(a_halted), 32'h0);
    check("irq_push_addr", 32'(a_address), 32'h1FF);
    check("irq_push_data", 32'(a_data_out), 32'h0001);
    check("irq_push_wt", 32'(a_memwt), 32'h1);
    run_a(20, "irq_handler_halt");
    for (int i = 0; i < 5; i++) step();
    check("irq_vec_pc", 32'(a_address), 32'h011);
    check("irq_still_halted", 32'(a_halted), 32'h1);
    check("irq_ack_once", 32'(ack_cnt - abase), 32'h1);
    check("irq_one_write", 32'(wa_cnt - base), 32'h1);
`else
    for (int i = 0; i < 5; i++) begin
      step();
      check("noirq_halted", 32'(a_halted), 32'h1);
    end
    check("noirq_ack", 32'(ack_cnt - abase), 32'h0);
    check("noirq_pc", 32'(a_address), 32'h001);
    check("noirq_no_write", 32'(wa_cnt - base), 32'h0);
`endif
    irq = 1'b0;

    // 32-bit data / 8-bit address: DEC wrap, zeroflag clear, PC wrap on JMP
    fill_b = 1'b1; step(); fill_b = 1'b0;
    load_b(8'h00, 32'h7000_0ECA); load_b(8'h01, 32'h5000_000E);
    load_b(8'h10, 32'h4000_0020); load_b(8'h11, 32'h3000_0080);
    load_b(8'h12, 32'h5000_00EA); load_b(8'hFD, 32'h5000_0004);
    b_rst_n = 1'b1;
    n = 0;
    while (!b_halted && n < 100) begin step(); n++; end
    check("b_halt", 32'(b_halted), 32'h1);
    check("b_dec_wrap", mem_b[8'h00], 32'hFFFF_FFFF);
    check("b_writes", 32'(wb_cnt), 32'h1);
    check("b_pc_wrap", 32'(b_address), 32'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
